demorgan_truth_table_sequencer: RTL and testbench
=================================================

// Module: demorgan_truth_table_sequencer
// PURPOSE
//  Self-checking stimulus controller for 3-input De Morgan gate DUTs (a,b,c -> d).
//  - On start: drives all 8 input vectors in ascending order {a,b,c} = 0..7
//    (a is the MSB, c the LSB).
//  - Holds each vector long enough for the output to settle, then samples d.
//  - Compares the sampled d against an expected truth table and reports pass/fail.
//  - Sits between the gate under test and the board-level/bench status logic;
//    replaces free-running toggle stimulus with a clocked, repeatable sweep.
// PARAMETERS
//  EXPECTED  8'h7F  truth table; bit k = expected d for {a,b,c}=k (default ~(a&b&c))
//  SETTLE    2      clock cycles each vector is driven before its sample cycle (>=1)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  begin a sweep; sampled only in IDLE
//  dut_a      out  1  DUT input a (vector bit 2)
//  dut_b      out  1  DUT input b (vector bit 1)
//  dut_c      out  1  DUT input c (vector bit 0)
//  dut_d      in   1  DUT output d
//  busy       out  1  high in DRIVE, SAMPLE and DONE
//  done       out  1  one-cycle pulse: sweep complete, results valid
//  pass       out  1  1 = all 8 samples matched EXPECTED
//  captured   out  8  bit k = d sampled for vector k
//  err_count  out  4  number of mismatching vectors (0..8)
//  fail_idx   out  3  lowest mismatching vector index (0 when pass=1)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; every output is 0, including dut_a/b/c;
//    idx=0; settle counter=0.
//  - FSM states: IDLE, DRIVE, SAMPLE, DONE.
//    - IDLE: start=1 -> DRIVE with idx=0; captured, err_count, fail_idx and pass
//      cleared on the same edge.
//    - DRIVE: {dut_a,dut_b,dut_c}=idx for SETTLE cycles, then -> SAMPLE.
//    - SAMPLE: one cycle, vector still driven.
//      - At its end: captured[idx] <= dut_d.
//      - On mismatch with EXPECTED[idx]: err_count++; fail_idx <= idx on the
//        first mismatch only.
//      - idx==7 -> DONE; otherwise idx++ -> DRIVE.
//    - DONE: done=1 for exactly one cycle; pass = (err_count==0); dut_a/b/c
//      return to 0; -> IDLE.
//  - Timing: edge 0 is the edge that accepts start. Vector k is sampled at edge
//    (k+1)*(SETTLE+1). done is high for the cycle after edge 8*(SETTLE+1)
//    (edge 24 at defaults).
//  - pass, captured, err_count and fail_idx hold their values until the next
//    accepted start.
//  - start while busy (any non-IDLE state, including DONE) is ignored; there is
//    no queuing.
//  - start held high continuously re-arms only after returning to IDLE, so
//    back-to-back sweeps are 8*(SETTLE+1)+2 cycles apart.
//  - The final-vector mismatch is included in pass (next-value compare, no
//    one-cycle lag).
//  - err_count is 4 bits and cannot overflow (max 8). idx does not wrap; the
//    transition is taken at 7.
//  - Reset mid-sweep aborts immediately with no done pulse; results are zeroed.
//  - dut_d is sampled synchronously; the DUT is purely combinational.
//    Metastability is out of scope.
// STRUCTURE
//  - Shared package/include demorgan_pkg:
//    - state encodings ST_IDLE/ST_DRIVE/ST_SAMPLE/ST_DONE
//    - N_VEC=8
//    - truth-table constants EXP_NAND3=8'h7F, EXP_NOR3=8'h01, EXP_AND3=8'h80,
//      EXP_OR3=8'hFE
//  - One sub-module, demorgan_settle_timer: loadable down-counter, width
//    $clog2(SETTLE+1).
//    - Inputs: load, en.
//    - Output: expired.
//    - Asynchronous reset to 0.
//  - FSM, vector index, capture and compare logic stay in the top module.
// TESTING
//  1. rst=1 mid-clock -> all outputs 0 at once; busy=0; dut_a/b/c=0.
//  2. Real gate, EXPECTED=8'h7F, 1-cycle start -> {a,b,c} steps 000..111, each
//     held 3 cycles; done at edge 24; captured=8'h7F, pass=1, err_count=0.
//  3. dut_d forced to 1 -> captured=8'hFF, pass=0, err_count=1, fail_idx=7.
//  4. dut_d forced to 0 -> captured=8'h00, pass=0, err_count=7, fail_idx=0.
//  5. start pulsed at edges 5 and 24 (busy) -> ignored; the next start after
//     IDLE clears results and gives a second, identical sweep.
//  6. rst pulsed at edge 10 -> no done, results 0; then start -> full correct
//     sweep, pass=1.

Source files
------------

// File: rtl/demorgan_pkg.sv
// demorgan_pkg: state encodings and reference truth tables for the De Morgan sweep sequencer
package demorgan_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_DONE} state_t;
  localparam int N_VEC = 8;
  localparam logic [7:0] EXP_NAND3 = 8'h7F;
  localparam logic [7:0] EXP_NOR3  = 8'h01;
  localparam logic [7:0] EXP_AND3  = 8'h80;
  localparam logic [7:0] EXP_OR3   = 8'hFE;
endpackage

// File: rtl/demorgan_settle_timer.sv
// demorgan_settle_timer: loadable down-counter; expired once SETTLE drive cycles have elapsed
module demorgan_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(SETTLE + 1);
  logic [W-1:0] r_cnt;
  // loading SETTLE-1 makes the cycle in which the count reads zero the last drive cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= W'(SETTLE - 1);
    else if (en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign expired = r_cnt == '0;
endmodule

// File: rtl/demorgan_truth_table_sequencer.sv
// demorgan_truth_table_sequencer: sweeps {a,b,c}=0..7 into a gate, samples d and checks it against EXPECTED
module demorgan_truth_table_sequencer
  import demorgan_pkg::*;
#(
  parameter logic [7:0] EXPECTED = EXP_NAND3,
  parameter int         SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [3:0] err_count,
  output logic [2:0] fail_idx
);
  state_t     r_state;
  logic [2:0] r_idx, r_vec, r_fidx;
  logic       r_busy, r_done, r_pass;
  logic [7:0] r_cap;
  logic [3:0] r_err;
  logic       w_expired, w_mis, w_load;
  logic [3:0] w_err_nxt;
  assign w_load    = (r_state == ST_IDLE && start) || (r_state == ST_SAMPLE && r_idx != 3'd7);
  assign w_mis     = dut_d != EXPECTED[r_idx];
  assign w_err_nxt = r_err + {3'b000, w_mis};
  demorgan_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .en      (r_state == ST_DRIVE),
    .expired (w_expired)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_cap   <= '0;
      r_err   <= '0;
      r_fidx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_DRIVE;
          r_idx   <= '0;
          r_vec   <= '0;
          r_busy  <= 1'b1;
          r_pass  <= 1'b0;
          r_cap   <= '0;
          r_err   <= '0;
          r_fidx  <= '0;
        end
        ST_DRIVE: if (w_expired) r_state <= ST_SAMPLE;
        ST_SAMPLE: begin
          r_cap[r_idx] <= dut_d;
          r_err        <= w_err_nxt;
          if (w_mis && r_err == '0) r_fidx <= r_idx;
          // pass uses the post-sample count so the last vector is not lost
          if (r_idx == 3'd7) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= w_err_nxt == '0;
            r_vec   <= '0;
          end else begin
            r_state <= ST_DRIVE;
            r_idx   <= r_idx + 3'd1;
            r_vec   <= r_idx + 3'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign {dut_a, dut_b, dut_c} = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign captured  = r_cap;
  assign err_count = r_err;
  assign fail_idx  = r_fidx;
endmodule

// File: tb/tb_demorgan_truth_table_sequencer.sv
// tb_demorgan_truth_table_sequencer: scoreboard bench sweeping a NAND3 model and forced-output faults
module tb_demorgan_truth_table_sequencer;
  localparam logic [7:0] EXP = 8'h7F;
  localparam int S = 2;
  localparam int E = 8 * (S + 1);
  typedef struct packed {
    logic [7:0] cap;
    logic       pass;
    logic [3:0] err;
    logic [2:0] fidx;
  } res_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic dut_a, dut_b, dut_c, dut_d, busy, done, pass;
  logic [7:0] captured;
  logic [3:0] err_count;
  logic [2:0] fail_idx;
  int mode = 0;
  int checks = 0, failures = 0;
  res_t q[$];
  assign dut_d = (mode == 0) ? ~(dut_a & dut_b & dut_c) : (mode == 1);
  always #5 clk = ~clk;
  demorgan_truth_table_sequencer #(.EXPECTED(EXP), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d),
    .busy(busy), .done(done), .pass(pass),
    .captured(captured), .err_count(err_count), .fail_idx(fail_idx)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push_model(input int m);
    res_t r;
    logic [7:0] tt;
    logic [2:0] v;
    logic d;
    tt = EXP;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      d = (m == 0) ? ~(v[2] & v[1] & v[0]) : (m == 1);
      r.cap[k] = d;
      if (d != tt[k]) begin
        if (r.err == 0) r.fidx = v;
        r.err = r.err + 4'd1;
      end
    end
    r.pass = r.err == 0;
    q.push_back(r);
  endtask
  task automatic run_sweep(input int m, input bit pulses);
    res_t r;
    mode = m;
    push_model(m);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("clr_cap", captured, 0);
    chk("clr_err", err_count, 0);
    chk("clr_pass", pass, 0);
    chk("busy_start", busy, 1);
    for (int e = 1; e <= E + 1; e++) begin
      start = pulses && (e == 5 || e == E);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e < E) begin
        chk("vec", {dut_a, dut_b, dut_c}, e / (S + 1));
        chk("busy_run", busy, 1);
        chk("done_early", done, 0);
      end else if (e == E) begin
        chk("done_edge", done, 1);
        chk("vec_done", {dut_a, dut_b, dut_c}, 0);
        if (q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          r = q.pop_front();
          chk("captured", captured, r.cap);
          chk("pass", pass, r.pass);
          chk("err_count", err_count, r.err);
          chk("fail_idx", fail_idx, r.fidx);
        end
      end else begin
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
      end
    end
  endtask
  initial begin
    bit seen;
    #2 rst = 1'b1;
    #1;
    chk("rst_vec", {dut_a, dut_b, dut_c}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", {done, pass, captured, err_count, fail_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    run_sweep(0, 1'b1);
    run_sweep(0, 1'b0);
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_vec", {dut_a, dut_b, dut_c}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res", {done, pass, captured, err_count, fail_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen |= done | busy;
    end
    chk("abort_quiet", seen, 0);
    run_sweep(0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
